fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port pc_write, input, 1: 1 = advance or redirect PC; 0 = stall (from hazard unit).
REQ-004 SHALL have port pc_src, input, 2: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-005 SHALL have port branch_target, input, 32: branch destination.
REQ-006 SHALL have ports jump_index (input, 26) and jump_page (input, 4): jump index and page from ID stage.
REQ-007 SHALL have port jr_target, input, 32: register jump destination.
REQ-008 SHALL have ports imem_req (output, 1) and imem_addr (output, 32): instruction memory request and address.
REQ-009 SHALL have ports imem_ready (input, 1) and imem_rdata (input, 32): same-cycle memory response.
REQ-010 SHALL have port instruction, output, 32: instruction to IF/ID register.
REQ-011 SHALL have ports pc_plus_4 (output, 32) and pc_page (output, 4): fetch PC+4 and its bits [31:28].
REQ-012 SHALL have port fetch_valid, output, 1: instruction is valid this cycle.
REQ-013 SHALL have port redirect_flush, output, 1: drives IF/ID flush.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH and HOLD; IDLE SHALL move unconditionally to FETCH after one cycle.
REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; in IDLE and HOLD, imem_req SHALL be 0.
REQ-016 fetch_valid SHALL be (FETCH and imem_ready) or HOLD, forced to 0 whenever redirect_flush is 1.
REQ-017 instruction SHALL be imem_rdata in FETCH, held_instr in HOLD, and 32'h0 whenever fetch_valid is 0.
REQ-018 redirect_flush SHALL be combinational pc_write and pc_src!=00, valid in any state except IDLE.
REQ-019 On redirect, pc SHALL load the target next edge, with target low 2 bits forced to 00, and state SHALL go to FETCH.
REQ-020 Targets SHALL be: branch = branch_target; jump = {jump_page, jump_index, 2'b00}; jump-register = jr_target.
REQ-021 In FETCH with imem_ready=1, pc_write=1 and no redirect, pc SHALL become pc+4 and state SHALL stay FETCH.
REQ-022 In FETCH with imem_ready=1 and pc_write=0, imem_rdata SHALL latch into held_instr and state SHALL go to HOLD.
REQ-023 In FETCH with imem_ready=0 and no redirect, pc SHALL hold and the request SHALL stay asserted.
REQ-024 In HOLD with pc_write=1 and no redirect, pc SHALL become pc+4 and state SHALL go to FETCH; a redirect SHALL discard held_instr.
REQ-025 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 pc_plus_4 SHALL be pc+4 combinational, and pc_page SHALL equal pc_plus_4[31:28].

Reset
REQ-027 rst SHALL set pc=0, state=IDLE, held_instr=0 and counters=0.
REQ-028 During and one cycle after reset, outputs SHALL be imem_req=0, fetch_valid=0, instruction=0 and redirect_flush=0.
REQ-029 Reset asserted mid-fetch or in HOLD SHALL abandon the fetch and discard held_instr immediately.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: outputs fetch_count[31:0] and stall_count[31:0] SHALL exist.
REQ-031 fetch_count SHALL increment on each valid instruction accepted with pc_write=1 and no redirect; stall_count SHALL increment each non-IDLE cycle with pc_write=0; both SHALL saturate at 0xFFFFFFFF.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: counters and their ports SHALL be absent, with no other behavioural change.

Structure
REQ-033 The shared constants header SHALL hold pc_src encodings, FSM state encodings, WORD_ZERO and RESET_PC (0).
REQ-034 Next-PC target selection and alignment SHALL be a combinational sub-module, fetch_pc_mux; FSM, PC and held_instr SHALL stay in fetch_unit.

Verification
REQ-035 Reset, then imem_ready=1 and pc_write=1 held: imem_addr SHALL be 0,4,8 on successive FETCH cycles, with fetch_valid=1 and instruction=imem_rdata.
REQ-036 Stall with pc_write=0 while rdata=0x8C010004: state SHALL be HOLD, imem_req=0, instruction SHALL stay 0x8C010004; release SHALL give pc+4.
REQ-037 Jump with pc_src=10, jump_page=0x4, jump_index=0x0000010: redirect_flush=1 and fetch_valid=0 that cycle, then next imem_addr=0x40000040.
REQ-038 Memory wait with imem_ready=0 for 3 cycles: imem_addr SHALL be constant and fetch_valid=0; then a branch to 0x00000103 SHALL give next imem_addr=0x00000100.
REQ-039 PC preloaded by jr to 0xFFFFFFFC then one accept: next imem_addr=0x00000000 and pc_page=0x0.
REQ-040 rst asserted in HOLD: fetch_valid SHALL drop in the same cycle, and after release imem_addr=0 from the first FETCH; with FETCH_PERF_CNT_EN, 5 stall cycles SHALL read stall_count=5.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch unit: PC source encodings, FSM states and reset values.
package fetch_unit_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle; the fetch unit is the master.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_pc_mux.sv
// Combinational next-PC selection: sequential, branch, jump or jump-register, word aligned.
module fetch_pc_mux
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] pc_plus_4_i,
  input  logic [31:0] branch_target_i,
  input  logic [25:0] jump_index_i,
  input  logic [3:0]  jump_page_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] target;

  always_comb begin
    target = pc_plus_4_i;
    case (pc_src_i)
      PC_SRC_BRANCH: target = branch_target_i;
      PC_SRC_JUMP:   target = {jump_page_i, jump_index_i, 2'b00};
      PC_SRC_JR:     target = jr_target_i;
      default:       target = pc_plus_4_i;
    endcase
    // Misaligned redirect targets are silently word-aligned.
    next_pc_o = {target[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FETCH/HOLD FSM, PC register and stall buffer.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        branch_target,
  input  logic [25:0]        jump_index,
  input  logic [3:0]         jump_page,
  input  logic [31:0]        jr_target,
  fetch_unit_if.master       imem,
  output logic [31:0]        instruction,
  output logic [31:0]        pc_plus_4,
  output logic [3:0]         pc_page,
  output logic               fetch_valid,
  output logic               redirect_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  held_instr_q;
  logic         imem_req_q;
  logic [31:0]  next_pc;
  logic         in_fetch;
  logic         in_hold;

  assign in_fetch = (state_q == ST_FETCH);
  assign in_hold  = (state_q == ST_HOLD);

  assign pc_plus_4 = pc_q + 32'd4;
  assign pc_page   = pc_plus_4[31:28];

  fetch_pc_mux u_pc_mux (
    .pc_src_i        (pc_src),
    .pc_plus_4_i     (pc_plus_4),
    .branch_target_i (branch_target),
    .jump_index_i    (jump_index),
    .jump_page_i     (jump_page),
    .jr_target_i     (jr_target),
    .next_pc_o       (next_pc)
  );

  assign redirect_flush = (state_q != ST_IDLE) && pc_write && (pc_src != PC_SRC_SEQ);

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;

  assign fetch_valid = !redirect_flush && ((in_fetch && imem.imem_ready) || in_hold);
  assign instruction = !fetch_valid ? WORD_ZERO :
                       (in_fetch ? imem.imem_rdata : held_instr_q);

  // next_pc already equals pc+4 when pc_src is sequential, so every PC update uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      held_instr_q <= WORD_ZERO;
      imem_req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          if (redirect_flush) begin
            pc_q <= next_pc;
          end else if (imem.imem_ready) begin
            if (pc_write) begin
              pc_q <= next_pc;
            end else begin
              held_instr_q <= imem.imem_rdata;
              state_q      <= ST_HOLD;
              imem_req_q   <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (pc_write) begin
            pc_q       <= next_pc;
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
            if (redirect_flush) begin
              held_instr_q <= WORD_ZERO;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetch_valid && pc_write && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if ((state_q != ST_IDLE) && !pc_write && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= WORD_ZERO;
      stall_count_q <= WORD_ZERO;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by randomized traffic.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] branch_target = 32'h0;
  logic [25:0] jump_index = 26'h0;
  logic [3:0]  jump_page = 4'h0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc_plus_4;
  logic [3:0]  pc_page;
  logic        fetch_valid;
  logic        redirect_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_index     (jump_index),
    .jump_page      (jump_page),
    .jr_target      (jr_target),
    .imem           (imem.master),
    .instruction    (instruction),
    .pc_plus_4      (pc_plus_4),
    .pc_page        (pc_page),
    .fetch_valid    (fetch_valid),
    .redirect_flush (redirect_flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        flush;
    logic [31:0] pc4;
    logic [3:0]  page;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  // Reference model: where the fetcher is pointing and what it is doing.
  localparam int M_IDLE = 0;
  localparam int M_FETCHING = 1;
  localparam int M_HOLDING = 2;
  int          m_mode = M_IDLE;
  logic [31:0] m_pc = 0;
  logic [31:0] m_held = 0;
  logic [31:0] m_fc = 0;
  logic [31:0] m_sc = 0;

  task automatic tick();
    exp_t        e;
    logic        redirect;
    logic [31:0] tgt;
    if (rst) begin
      m_mode = M_IDLE;
      m_pc   = 32'h0;
      m_held = 32'h0;
      m_fc   = 32'h0;
      m_sc   = 32'h0;
    end
    redirect = (m_mode != M_IDLE) && pc_write && (pc_src != 2'b00);
    e.cyc   = cyc_n;
    e.req   = (m_mode == M_FETCHING);
    e.addr  = m_pc;
    e.valid = !redirect && ((m_mode == M_FETCHING && imem.imem_ready) || m_mode == M_HOLDING);
    e.instr = !e.valid ? 32'h0 : ((m_mode == M_FETCHING) ? imem.imem_rdata : m_held);
    e.flush = redirect;
    e.pc4   = m_pc + 32'd4;
    e.page  = e.pc4[31:28];
    e.fc    = m_fc;
    e.sc    = m_sc;
    exp_q.push_back(e);

    if (!rst) begin
      if (e.valid && pc_write && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      if (m_mode != M_IDLE && !pc_write && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      case (pc_src)
        2'b01:   tgt = branch_target;
        2'b10:   tgt = {jump_page, jump_index, 2'b00};
        default: tgt = jr_target;
      endcase
      if (m_mode == M_IDLE) begin
        m_mode = M_FETCHING;
      end else if (redirect) begin
        m_pc   = tgt & 32'hFFFF_FFFC;
        m_held = 32'h0;
        m_mode = M_FETCHING;
      end else if (m_mode == M_FETCHING && imem.imem_ready) begin
        if (pc_write) m_pc = m_pc + 32'd4;
        else begin
          m_held = imem.imem_rdata;
          m_mode = M_HOLDING;
        end
      end else if (m_mode == M_HOLDING && pc_write) begin
        m_pc   = m_pc + 32'd4;
        m_mode = M_FETCHING;
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic rtick();
    imem.imem_rdata = $urandom;
    tick();
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares every cycle's outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("cyc %0d req=%b addr=%h valid=%b instr=%h flush=%b", e.cyc,
                 imem.imem_req, imem.imem_addr, fetch_valid, instruction, redirect_flush);
        chk("imem_req", e.cyc, {31'h0, imem.imem_req}, {31'h0, e.req});
        if (e.req) chk("imem_addr", e.cyc, imem.imem_addr, e.addr);
        chk("fetch_valid", e.cyc, {31'h0, fetch_valid}, {31'h0, e.valid});
        chk("instruction", e.cyc, instruction, e.instr);
        chk("redirect_flush", e.cyc, {31'h0, redirect_flush}, {31'h0, e.flush});
        chk("pc_plus_4", e.cyc, pc_plus_4, e.pc4);
        chk("pc_page", e.cyc, {28'h0, pc_page}, {28'h0, e.page});
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", e.cyc, fetch_count, e.fc);
        chk("stall_count", e.cyc, stall_count, e.sc);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    // Reset, then straight-line fetch from 0.
    rst = 1'b1; rtick(); rtick();
    rst = 1'b0; pc_write = 1'b1; imem.imem_ready = 1'b1; pc_src = 2'b00;
    rtick();
    repeat (3) rtick();
    // Stall into HOLD with a known word, then release.
    imem.imem_rdata = 32'h8C01_0004; pc_write = 1'b0; tick();
    repeat (2) rtick();
    pc_write = 1'b1; rtick(); rtick();
    // Jump to page 4.
    pc_src = 2'b10; jump_page = 4'h4; jump_index = 26'h000_0010; rtick();
    pc_src = 2'b00; rtick();
    // Memory wait, then misaligned branch.
    imem.imem_ready = 1'b0; repeat (3) rtick();
    pc_src = 2'b01; branch_target = 32'h0000_0103; rtick();
    pc_src = 2'b00; imem.imem_ready = 1'b1; rtick();
    // PC wrap through jr to the top word.
    pc_src = 2'b11; jr_target = 32'hFFFF_FFFC; rtick();
    pc_src = 2'b00; rtick(); rtick();
    // Reset while holding, then five stall cycles.
    pc_write = 1'b0; rtick(); rtick();
    rst = 1'b1; rtick();
    rst = 1'b0; rtick();
    repeat (5) rtick();
    pc_write = 1'b1; rtick(); rtick();
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      pc_write        = ($urandom_range(0, 9) < 8);
      imem.imem_ready = ($urandom_range(0, 3) != 0);
      pc_src          = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      branch_target   = $urandom;
      jump_index      = 26'($urandom);
      jump_page       = 4'($urandom);
      jr_target       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      rtick();
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc_n, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
